arb_mux_n: RTL

- Parametrised N-input selector with a registered output stage and valid/ready handshakes on every channel. Successor to the combinational 3-to-1 datapath mux.
- Two selection modes:
  - explicit select (mux behaviour);
  - round-robin arbitration among valid inputs.
- Sits between multiple producers (e.g. forwarding sources, writeback requesters) and one consumer that may stall.
- Flags illegal select codes instead of driving X.

---
 rtl/arb_mux_n_pkg.sv | 13 +
 rtl/arb_mux_n_rr.sv | 39 +++
 rtl/arb_mux_n.sv | 112 +++++++++++
 3 files changed

// File: rtl/arb_mux_n_pkg.sv
// Shared definitions for the arb_mux_n selector.
// Contents: mode encodings and the helper that sizes select/out_src from the channel count.
package arb_mux_n_pkg;

  localparam logic MODE_SEL = 1'b0;  // explicit select
  localparam logic MODE_RR  = 1'b1;  // round-robin among valid inputs

  // Index width for n channels; never narrower than one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_mux_n_rr.sv
// rr_arbiter_n: combinational round-robin priority encoder.
// Ports:
//   req         in   NUM_IN  request vector
//   last_grant  in   SEL_W   most recently served channel
//   grant       out  SEL_W   chosen channel (0 when nothing requests)
//   grant_valid out  1       at least one request was present
module rr_arbiter_n
  import arb_mux_n_pkg::*;
#(
  parameter  int unsigned NUM_IN = 3,
  localparam int unsigned SEL_W  = sel_w(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  last_grant,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_valid
);

  // Two passes: channels at or below the pointer are the wrap-around
  // candidates; channels above the pointer have priority and overwrite them.
  // Each pass runs downward so the lowest matching index is the survivor.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (req[i] && (SEL_W'(i) <= last_grant)) begin
        grant       = SEL_W'(i);
        grant_valid = 1'b1;
      end
    end
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (req[i] && (SEL_W'(i) > last_grant)) begin
        grant       = SEL_W'(i);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// arb_mux_n: N-input selector with a registered, back-pressurable output stage.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   mode        0 = explicit select, 1 = round-robin
//   select      channel index used in explicit mode
//   in_data     packed channels, channel i at [i*DATAWIDTH +: DATAWIDTH]
//   in_valid    per-channel valid
//   in_ready    per-channel ready (combinational, at most one bit high)
//   out_data    registered selected word
//   out_valid   out_data holds an unconsumed word
//   out_ready   consumer accepts the word
//   out_src     channel that produced out_data
//   sel_err     one-cycle pulse for an out-of-range explicit select with requests pending
module arb_mux_n
  import arb_mux_n_pkg::*;
#(
  parameter  int unsigned DATAWIDTH = 32,
  parameter  int unsigned NUM_IN    = 3,
  localparam int unsigned SEL_W     = sel_w(NUM_IN)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mode,
  input  logic [SEL_W-1:0]            select,
  input  logic [NUM_IN*DATAWIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]           in_valid,
  output logic [NUM_IN-1:0]           in_ready,
  output logic [DATAWIDTH-1:0]        out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SEL_W-1:0]            out_src,
  output logic                        sel_err
);

  logic [SEL_W-1:0]     last_grant;
  logic [SEL_W-1:0]     rr_grant;
  logic                 rr_valid;
  logic [SEL_W-1:0]     grant;
  logic                 grant_valid;
  logic                 load_en;
  logic                 sel_legal;
  logic                 sel_req;
  logic                 xfer;
  logic                 sel_err_nxt;
  logic [DATAWIDTH-1:0] grant_data;

  rr_arbiter_n #(.NUM_IN(NUM_IN)) u_rr (
    .req         (in_valid),
    .last_grant  (last_grant),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  assign load_en   = !out_valid || out_ready;
  assign sel_legal = 32'(select) < NUM_IN;

  // Request bit of the explicitly selected channel; 0 for out-of-range codes.
  always_comb begin
    sel_req = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (select == SEL_W'(i)) sel_req = in_valid[i];
    end
  end

  // Grant source depends on mode; explicit mode only grants a legal, requesting channel.
  always_comb begin
    if (mode == MODE_RR) begin
      grant       = rr_grant;
      grant_valid = rr_valid;
    end else begin
      grant       = select;
      grant_valid = sel_legal && sel_req;
    end
  end

  assign xfer        = load_en && grant_valid;
  assign sel_err_nxt = (mode == MODE_SEL) && !sel_legal && (|in_valid);

  // One-hot ready and data mux for the granted channel.
  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant == SEL_W'(i)) begin
        in_ready[i] = xfer;
        grant_data  = in_data[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  // Output stage: load on transfer, clear on drain, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      sel_err    <= 1'b0;
      last_grant <= SEL_W'(NUM_IN - 1);
    end else begin
      sel_err <= sel_err_nxt;
      if (xfer) begin
        out_data  <= grant_data;
        out_src   <= grant;
        out_valid <= 1'b1;
        if (mode == MODE_RR) last_grant <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
